// File: rtl/pwm_pkg.sv
// Shared types, constants and arithmetic helpers for the PWM control blocks.
package pwm_pkg;

    // Default PWM resolution and the matching full-scale duty (100 %).
    localparam int PWM_R    = 8;
    localparam int DUTY_MAX = 1 << PWM_R;

    // Ramp sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } seq_state_t;

    // Limit a requested duty to the full-scale value.
    function automatic int clamp_duty(input int value, input int max_duty);
        return (value > max_duty) ? max_duty : value;
    endfunction

    // Move cur one step toward tgt without overshooting it.
    // A step size of zero jumps straight to the target.
    function automatic int sat_step(input int cur, input int tgt, input int step_size);
        if (step_size == 0) begin
            return tgt;
        end
        if (cur < tgt) begin
            return (cur + step_size >= tgt) ? tgt : cur + step_size;
        end
        if (cur > tgt) begin
            return (cur - step_size <= tgt) ? tgt : cur - step_size;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/pwm_step_timer.sv
// Interval counter that emits a one-cycle step pulse every `interval` clocks
// while enabled. `interval` must be non-zero; the sequencer guarantees this.
module pwm_step_timer
#(
    parameter int STEP_BITS = 16
)
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [STEP_BITS-1:0] interval,
    output logic                 step
);

    logic [STEP_BITS-1:0] count;

    // Step fires on the cycle whose closing edge sees count == interval-1.
    assign step = enable && !clear && (count == interval - STEP_BITS'(1));

    // Free-running counter, restarted by clear and on every step event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state is written with non-blocking assignments so
            // every register samples the pre-edge values of its neighbours.
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= step ? '0 : count + STEP_BITS'(1);
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Ramps the duty fed to pwm_improved toward a commanded target at a
// programmable step interval, and latches the PWM prescale value.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int R                 = PWM_R,
    parameter int TIMER_BITS        = 8,
    parameter int STEP_BITS         = 16,
    parameter int RESET_FINAL_VALUE = 194
)
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [R:0]            cmd_target,
    input  logic [R-1:0]          cmd_step,
    input  logic [STEP_BITS-1:0]  cmd_interval,
    input  logic [TIMER_BITS-1:0] cmd_final_value,
    input  logic                  abort,
    output logic [R:0]            duty,
    output logic [TIMER_BITS-1:0] FINAL_VALUE,
    output logic                  busy,
    output logic                  done
);

    localparam int DUTY_LIMIT = 1 << R;

    seq_state_t           state;
    seq_state_t           state_next;
    logic [R:0]           target_q;
    logic [R-1:0]         step_q;
    logic [STEP_BITS-1:0] interval_q;
    logic                 accept;
    logic                 step_pulse;
    logic                 stepping;
    logic [R:0]           target_clamped;
    logic [R:0]           duty_next;
    logic                 reached;

    assign accept         = cmd_valid && cmd_ready;
    assign target_clamped = (R+1)'(clamp_duty(int'(cmd_target), DUTY_LIMIT));
    assign duty_next      = (R+1)'(sat_step(int'(duty), int'(target_q), int'(step_q)));
    assign reached        = (duty_next == target_q);
    // abort takes priority over a coincident step event.
    assign stepping       = (state == RAMP) && step_pulse && !abort;

    pwm_step_timer #(
        .STEP_BITS (STEP_BITS)
    ) u_step_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (accept),
        .enable   (busy),
        .interval (interval_q),
        .step     (step_pulse)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic: leave RAMP on abort or when the target is reached.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned
        // and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RAMP;
            RAMP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (step_pulse && reached) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: handshake ready while idle, busy while ramping.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    cmd_ready = 1'b1;
            RAMP:    busy      = 1'b1;
            default: cmd_ready = 1'b1;
        endcase
    end

    // Command latch, duty update on step events, and the completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q    <= '0;
            step_q      <= '0;
            interval_q  <= STEP_BITS'(1);
            duty        <= '0;
            FINAL_VALUE <= TIMER_BITS'(RESET_FINAL_VALUE);
            done        <= 1'b0;
        end else begin
            done <= stepping && reached;
            if (accept) begin
                target_q    <= target_clamped;
                step_q      <= cmd_step;
                interval_q  <= (cmd_interval == '0) ? STEP_BITS'(1) : cmd_interval;
                FINAL_VALUE <= cmd_final_value;
            end
            if (stepping) begin
                duty <= duty_next;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer with a trajectory-based model.
module tb_pwm_duty_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [8:0]  cmd_target = '0;
    logic [7:0]  cmd_step = '0;
    logic [15:0] cmd_interval = '0;
    logic [7:0]  cmd_final_value = '0;
    logic        abort = 1'b0;
    logic [8:0]  duty;
    logic [7:0]  FINAL_VALUE;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;
    int mdl_duty = 0;   // duty the model believes the DUT holds while idle

    pwm_duty_sequencer #(
        .R                 (8),
        .TIMER_BITS        (8),
        .STEP_BITS         (16),
        .RESET_FINAL_VALUE (194)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_target      (cmd_target),
        .cmd_step        (cmd_step),
        .cmd_interval    (cmd_interval),
        .cmd_final_value (cmd_final_value),
        .abort           (abort),
        .duty            (duty),
        .FINAL_VALUE     (FINAL_VALUE),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Asynchronous reset: outputs must change before any clock edge.
    task automatic test_reset();
        logic [20:0] obs, exp;
        #3 reset_n = 1'b0;
        #1;
        obs = {duty, FINAL_VALUE, cmd_ready, busy, done, 1'b0};
        exp = {9'd0, 8'd194, 1'b1, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mdl_duty = 0;
    endtask

    // Issue one command and follow the whole ramp cycle by cycle against a
    // precomputed list of duty values at each step event.
    task automatic run_ramp(input int tgt, input int stp, input int iv_raw, input int fv);
        int q[$];
        int t, iv, v, n, k, d;
        logic [19:0] obs, exp;
        logic ex_busy, ex_done;
        t  = (tgt > 256) ? 256 : tgt;
        iv = (iv_raw == 0) ? 1 : iv_raw;
        v  = mdl_duty;
        do begin
            if (stp == 0)                v = t;
            else if (v < t)              v = (v + stp > t) ? t : v + stp;
            else if (v > t)              v = (v - stp < t) ? t : v - stp;
            q.push_back(v);
        end while (v != t);
        n = q.size();

        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
        end
        cmd_valid       = 1'b1;
        cmd_target      = 9'(tgt);
        cmd_step        = 8'(stp);
        cmd_interval    = 16'(iv_raw);
        cmd_final_value = 8'(fv);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        // Accept edge: duty unchanged, prescale already updated.
        obs = {duty, busy, done, cmd_ready, FINAL_VALUE};
        exp = {9'(mdl_duty), 1'b1, 1'b0, 1'b0, 8'(fv)};
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL accept_edge t=%0d s=%0d i=%0d: got %h expected %h", tgt, stp, iv_raw, obs, exp);
        end

        for (int e = 1; e <= iv * n + 1; e++) begin
            @(negedge clk);
            k = e / iv;
            d = (k == 0) ? mdl_duty : q[((k > n) ? n : k) - 1];
            ex_busy = (e < iv * n);
            ex_done = (e == iv * n);
            obs = {duty, busy, done, cmd_ready, FINAL_VALUE};
            exp = {9'(d), ex_busy, ex_done, !ex_busy, 8'(fv)};
            n_checks++;
            if (obs !== exp) begin
                n_errors++;
                $display("FAIL ramp t=%0d s=%0d i=%0d edge=%0d {duty,busy,done,rdy,fv}: got %h expected %h",
                         tgt, stp, iv_raw, e, obs, exp);
            end
        end
        mdl_duty = t;
    endtask

    task automatic test_ramp_up();
        run_ramp(64, 16, 4, 194);
    endtask

    task automatic test_ramp_down();
        run_ramp(200, 0, 1, 100);
        run_ramp(50, 64, 1, 194);
    endtask

    task automatic test_clamp_jump();
        run_ramp(300, 0, 0, 77);
        run_ramp(256, 9, 3, 12);   // target already equal to duty
    endtask

    task automatic test_abort_busy();
        run_ramp(0, 0, 1, 194);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 9'd256; cmd_step = 8'd8;
        cmd_interval = 16'd10; cmd_final_value = 8'd33;
        @(posedge clk);
        @(negedge clk);
        // Competing command held during the ramp must be ignored.
        cmd_target = 9'd0; cmd_step = 8'd0; cmd_interval = 16'd1; cmd_final_value = 8'd5;
        for (int e = 1; e <= 29; e++) begin
            @(negedge clk);
            n_checks++;
            if ({cmd_ready, busy, duty, FINAL_VALUE} !== {1'b0, 1'b1, 9'(8 * (e / 10)), 8'd33}) begin
                n_errors++;
                $display("FAIL busy_ignore edge=%0d: rdy=%b busy=%b duty=%0d fv=%0d expected rdy=0 busy=1 duty=%0d fv=33",
                         e, cmd_ready, busy, duty, FINAL_VALUE, 8 * (e / 10));
            end
        end
        abort = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if ({duty, busy, done, cmd_ready} !== {9'd16, 1'b0, 1'b0, 1'b1}) begin
            n_errors++;
            $display("FAIL abort_step: duty=%0d busy=%b done=%b rdy=%b expected duty=16 busy=0 done=0 rdy=1",
                     duty, busy, done, cmd_ready);
        end
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({duty, done, busy} !== {9'd16, 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL abort_hold: duty=%0d done=%b busy=%b expected 16/0/0", duty, done, busy);
            end
        end
        mdl_duty = 16;
    endtask

    task automatic test_reset_mid_ramp();
        @(negedge clk);
        cmd_valid = 1'b1; cmd_target = 9'd200; cmd_step = 8'd32;
        cmd_interval = 16'd3; cmd_final_value = 8'd9;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (7) @(negedge clk);
        n_checks++;
        if (duty !== 9'd80) begin
            n_errors++;
            $display("FAIL pre_reset_duty: got %0d expected 80", duty);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({duty, FINAL_VALUE, cmd_ready, busy, done} !== {9'd0, 8'd194, 1'b1, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_mid_ramp: duty=%0d fv=%0d rdy=%b busy=%b done=%b expected 0/194/1/0/0",
                     duty, FINAL_VALUE, cmd_ready, busy, done);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({done, duty} !== {1'b0, 9'd0}) begin
            n_errors++;
            $display("FAIL reset_hold: done=%b duty=%0d expected 0/0", done, duty);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mdl_duty = 0;
        run_ramp(100, 25, 2, 50);
    endtask

    task automatic test_random();
        int tgt, stp, iv, fv;
        for (int i = 0; i < 10; i++) begin
            tgt = $urandom_range(0, 320);
            stp = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 90);
            iv  = $urandom_range(0, 5);
            fv  = $urandom_range(0, 255);
            run_ramp(tgt, stp, iv, fv);
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp_jump();
        test_abort_busy();
        test_reset_mid_ramp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Control block that drives the duty and FINAL_VALUE inputs of pwm_improved.
- Accepts ramp commands over a valid/ready handshake and steps duty toward the target at a programmable interval (soft-start, fade).
- Latches the PWM prescale value.
- Sits between the register/command interface and pwm_improved.

Parameters:
R, 8, PWM resolution; duty spans 0..2^R inclusive (R+1 bits)
TIMER_BITS, 8, width of FINAL_VALUE (PWM prescaler)
STEP_BITS, 16, width of the step-interval counter
RESET_FINAL_VALUE, 194, FINAL_VALUE driven out of reset

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_target  in  R+1  target duty; values above 2^R are clamped to 2^R
cmd_step  in  R  duty change per step event; 0 means jump straight to target
cmd_interval  in  STEP_BITS  clocks between step events; 0 is treated as 1
cmd_final_value  in  TIMER_BITS  prescale value for pwm_improved
abort  in  1  stop the ramp and hold the current duty
duty  out  R+1  to pwm_improved duty
FINAL_VALUE  out  TIMER_BITS  to pwm_improved FINAL_VALUE
busy  out  1  ramp in progress
done  out  1  one-cycle pulse when duty reaches target

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: duty=0, FINAL_VALUE=RESET_FINAL_VALUE, state=IDLE, busy=0, done=0, cmd_ready=1, interval counter=0.
- Reset asserted mid-ramp returns everything to these values immediately. No done pulse.
- States: IDLE, RAMP.
- cmd_ready=1 iff state==IDLE. busy=1 iff state==RAMP.
- Accept: the clock edge where cmd_valid && cmd_ready. On that edge:
  - latch the clamped target, step and interval (0 becomes 1);
  - FINAL_VALUE <= cmd_final_value;
  - counter <= 0;
  - state <= RAMP.
  - duty is unchanged on the accept edge.
- RAMP step timing:
  - Counter increments each clock.
  - A step event occurs on the edge where counter == interval-1; the counter returns to 0 on that edge.
  - The first step event therefore happens exactly interval edges after accept.
- Step event arithmetic:
  - duty < target: duty <= min(duty+step, target).
  - duty > target: duty <= max(duty-step, target).
  - step==0: duty <= target.
  - Compute in R+2 bits. No overshoot, no wrap below 0 or above 2^R.
- Completion:
  - On the step-event edge where the new duty equals the target, state <= IDLE and done <= 1.
  - done is high for exactly the following cycle, and cmd_ready is already 1 in that cycle.
  - If the target equals duty at accept, completion happens at the first step event, with duty unchanged.
- abort:
  - In RAMP, abort wins over a same-cycle step event: duty holds, state <= IDLE, no done pulse.
  - In IDLE, abort is ignored and does not block a same-cycle accept.
- Commands while busy: cmd_ready=0, so the command is not accepted. The command source must hold cmd_valid.
- Updates only on step edges: duty and FINAL_VALUE are registered outputs and change only on accept or step edges. pwm_improved re-samples them glitch-free.

Decomposition:
- pwm_pkg holds:
  - the state enum (IDLE, RAMP);
  - the DUTY_MAX constant (2^R);
  - a clamp/saturating-step function shared with future PWM blocks.
- One sub-module: pwm_step_timer.
  - Holds the interval counter.
  - Inputs: clear, enable, interval.
  - Output: a one-cycle step pulse.
- The FSM and duty arithmetic stay in pwm_duty_sequencer.

Test Plan:
- Reset: assert reset_n=0 mid-clock -> duty=0, FINAL_VALUE=194, cmd_ready=1, busy=0 without waiting for a clock edge.
- Ramp up: from duty 0, command target 64, step 16, interval 4, final 194 -> duty is 16/32/48/64 at edges 4/8/12/16 after accept; done is high for one cycle after edge 16; FINAL_VALUE=194 from the accept edge.
- Ramp down, uneven step: duty 200, command target 50, step 64, interval 1 -> duty 136, 72, 50 on consecutive edges, no undershoot; one done pulse.
- Clamp and jump: target 300, step 0, interval 0 -> duty=256 one edge after accept; done follows.
- Abort and busy: start a 0->256 ramp with step 8, interval 10. Drive cmd_valid with target 0 during RAMP -> cmd_ready=0 and the command is not taken. Assert abort on a step-event cycle -> duty holds its prior value, no done pulse, cmd_ready=1 next cycle.
- Reset mid-ramp: drop reset_n during a ramp -> duty=0, state IDLE, no done pulse. A new command after release ramps from 0.
